cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 8-bit CPU datapath (program counter, instruction ROM, decoder, register file, ALU).
- Steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Owns the zero flag, jump resolution and register-file write strobes, replacing single-cycle execute logic.
- Adds run, single-step, halt and resume control for debug.

---
 rtl/cpu_sequencer.sv | 137 +++++++++++++
 tb/tb_cpu_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU: walks each instruction through
// FETCH/DECODE/EXECUTE/WRITEBACK and adds run, single-step, halt and resume control.
module cpu_sequencer #(
  parameter int COUNT_W           = 8,
  parameter bit HALT_ON_SELF_JUMP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               resume,
  input  logic [2:0]         opcode,
  input  logic [2:0]         dest,
  input  logic [2:0]         src,
  input  logic               zero_flag,
  input  logic [3:0]         pc,
  output logic               ir_load,
  output logic               rf_write_en,
  output logic [2:0]         rf_write_addr,
  output logic [1:0]         rf_write_sel,
  output logic [7:0]         imm_data,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [3:0]         jump_addr,
  output logic               flag_q,
  output logic [2:0]         state,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [2:0] OP_JMP   = 3'b011;
  localparam logic [2:0] OP_JZ    = 3'b100;
  localparam logic [2:0] OP_MOV   = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] JUMP_DST = 3'b011;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;

  state_t     state_q, state_d;
  logic       step_mode, halt_pend;
  logic [2:0] opcode_q, dest_q, src_q;
  logic       is_jump, jump_taken, self_jump;

  // JNZ shares opcode 101 with MOV; dest 011 is what distinguishes the jump forms.
  assign is_jump    = (dest_q == JUMP_DST) &&
                      (opcode_q == OP_JMP || opcode_q == OP_JZ || opcode_q == OP_MOV);
  assign jump_taken = is_jump && ((opcode_q == OP_JMP) ||
                                  (opcode_q == OP_JZ  &&  flag_q) ||
                                  (opcode_q == OP_MOV && !flag_q));
  assign jump_addr  = {1'b0, src_q};
  assign self_jump  = HALT_ON_SELF_JUMP && jump_taken && (jump_addr == pc);

  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign rf_write_addr = dest_q;
  assign imm_data      = {6'b0, src_q[1:0]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (step || run) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        if (halt_pend || self_jump)  state_d = S_HALT;
        else if (step_mode || !run)  state_d = S_IDLE;
        else                         state_d = S_FETCH;
      end
      S_HALT:      if (resume) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_load      = 1'b0;
    rf_write_en  = 1'b0;
    rf_write_sel = SEL_ALU;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    if (state_q == S_FETCH) ir_load = 1'b1;
    if (state_q == S_WRITEBACK) begin
      pc_load = jump_taken;
      pc_inc  = !jump_taken;
      if (!is_jump && opcode_q != OP_CMP) begin
        rf_write_en = 1'b1;
        if (opcode_q == OP_MOV) rf_write_sel = src_q[2] ? SEL_IMM : SEL_REG;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= S_IDLE;
      flag_q      <= 1'b0;
      instr_count <= '0;
      step_mode   <= 1'b0;
      halt_pend   <= 1'b0;
      opcode_q    <= 3'b0;
      dest_q      <= 3'b0;
      src_q       <= 3'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && state_d == S_FETCH) step_mode <= step;

      // Entering HALT consumes the request; a request in HALT itself is ignored.
      if (state_q != S_HALT && state_d == S_HALT) halt_pend <= 1'b0;
      else if (state_q != S_HALT && halt_req)      halt_pend <= 1'b1;

      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        dest_q   <= dest;
        src_q    <= src;
      end

      if (state_q == S_EXECUTE && !is_jump && opcode_q != OP_MOV) flag_q <= zero_flag;

      if (state_q == S_WRITEBACK) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a small instruction model predicts each
// writeback, queues it, and the queue is checked when WRITEBACK appears.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step, halt_req, resume;
  logic [2:0] opcode, dest, src;
  logic       zero_flag;
  logic [3:0] pc;
  logic       ir_load, rf_write_en, pc_inc, pc_load, flag_q, halted;
  logic [2:0] rf_write_addr, state;
  logic [1:0] rf_write_sel;
  logic [7:0] imm_data, instr_count;
  logic [3:0] jump_addr;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_EXECUTE = 3'd3,
                         ST_WRITEBACK = 3'd4, ST_HALT = 3'd5;

  cpu_sequencer #(.COUNT_W(8), .HALT_ON_SELF_JUMP(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .resume(resume), .opcode(opcode), .dest(dest), .src(src),
    .zero_flag(zero_flag), .pc(pc), .ir_load(ir_load), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_write_sel(rf_write_sel), .imm_data(imm_data),
    .pc_inc(pc_inc), .pc_load(pc_load), .jump_addr(jump_addr), .flag_q(flag_q),
    .state(state), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [2:0] addr;
    logic [1:0] sel;
    logic [7:0] imm;
    logic       inc;
    logic       load;
    logic [3:0] jaddr;
    logic       flag;
    logic [7:0] count;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       m_flag  = 1'b0;
  logic [7:0] m_count = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input string tag);
    int budget = 20;
    while (state !== target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (state !== target) check({tag, "_timeout"}, {29'd0, state}, {29'd0, target});
  endtask

  // Reference behaviour of one instruction, written from the ISA description.
  function automatic exp_t predict(input logic [2:0] op, input logic [2:0] d,
                                   input logic [2:0] s, input logic zf);
    exp_t e;
    logic jmp, taken;
    jmp   = (d == 3'd3) && (op == 3'd3 || op == 3'd4 || op == 3'd5);
    taken = jmp && (op == 3'd3 || (op == 3'd4 && m_flag) || (op == 3'd5 && !m_flag));
    if (!jmp && op != 3'd5) m_flag = zf;
    m_count++;
    e.wr    = !jmp && (op != 3'd6);
    e.addr  = d;
    e.sel   = (op == 3'd5 && !jmp) ? (s[2] ? 2'b10 : 2'b01) : 2'b00;
    e.imm   = {6'd0, s[1:0]};
    e.inc   = !taken;
    e.load  = taken;
    e.jaddr = {1'b0, s};
    e.flag  = m_flag;
    e.count = m_count;
    return e;
  endfunction

  task automatic do_instr(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                          input logic zf, input logic [3:0] pcv, input logic hreq);
    exp_t e;
    wait_state(ST_FETCH, "fetch");
    opcode = op; dest = d; src = s; zero_flag = zf; pc = pcv;
    check("ir_load", {31'd0, ir_load}, 32'd1);
    sb.push_back(predict(op, d, s, zf));
    wait_state(ST_EXECUTE, "execute");
    check("exec_strobes", {28'd0, ir_load, rf_write_en, pc_inc, pc_load}, 32'd0);
    if (hreq) begin
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
    end
    wait_state(ST_WRITEBACK, "writeback");
    e = sb.pop_front();
    check("rf_write_en", {31'd0, rf_write_en}, {31'd0, e.wr});
    if (e.wr) begin
      check("rf_write_addr", {29'd0, rf_write_addr}, {29'd0, e.addr});
      check("rf_write_sel", {30'd0, rf_write_sel}, {30'd0, e.sel});
    end
    if (e.wr && e.sel == 2'b10) check("imm_data", {24'd0, imm_data}, {24'd0, e.imm});
    check("pc_inc", {31'd0, pc_inc}, {31'd0, e.inc});
    check("pc_load", {31'd0, pc_load}, {31'd0, e.load});
    if (e.load) check("jump_addr", {28'd0, jump_addr}, {28'd0, e.jaddr});
    check("flag_q", {31'd0, flag_q}, {31'd0, e.flag});
    @(negedge clk);
    check("instr_count", {24'd0, instr_count}, {24'd0, e.count});
    check("post_wb_strobes", {29'd0, rf_write_en, pc_inc, pc_load}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; resume = 1'b0;
    opcode = 3'd0; dest = 3'd0; src = 3'd0; zero_flag = 1'b0; pc = 4'd0;
    #1;
    check("reset_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("reset_outs", {26'd0, ir_load, rf_write_en, pc_inc, pc_load, flag_q, halted}, 32'd0);
    check("reset_count", {24'd0, instr_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;

    do_instr(3'b101, 3'd1, 3'b110, 1'b0, 4'd0, 1'b0);  // MOV R1,#2
    do_instr(3'b000, 3'd1, 3'd2,   1'b0, 4'd1, 1'b0);  // ADD R1,R2
    do_instr(3'b110, 3'd1, 3'd1,   1'b1, 4'd2, 1'b0);  // CMP R1,R1 -> flag 1
    do_instr(3'b100, 3'd3, 3'd5,   1'b0, 4'd3, 1'b0);  // JZ 5, taken
    do_instr(3'b101, 3'd3, 3'd5,   1'b0, 4'd5, 1'b0);  // JNZ 5, not taken
    do_instr(3'b101, 3'd2, 3'd3,   1'b0, 4'd6, 1'b0);  // MOV R2,R3, flag kept

    do_instr(3'b011, 3'd3, 3'd2,   1'b0, 4'd7, 1'b1);  // JMP 2 with halt request
    check("halt_state", {29'd0, state}, {29'd0, ST_HALT});
    check("halted", {31'd0, halted}, 32'd1);
    @(negedge clk); @(negedge clk);
    check("halt_ignores_run", {29'd0, state}, {29'd0, ST_HALT});
    check("halt_strobes", {28'd0, ir_load, rf_write_en, pc_inc, pc_load}, 32'd0);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_idle", {29'd0, state}, {29'd0, ST_IDLE});

    do_instr(3'b011, 3'd3, 3'd7,   1'b0, 4'd7, 1'b0);  // JMP 7 at pc 7
    check("self_jump_halt", {29'd0, state}, {29'd0, ST_HALT});
    run    = 1'b0;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_idle2", {29'd0, state}, {29'd0, ST_IDLE});

    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    do_instr(3'b001, 3'd4, 3'd5,   1'b0, 4'd8, 1'b0);  // single-stepped SUB
    check("step_idle", {29'd0, state}, {29'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    check("step_stays_idle", {29'd0, state}, {29'd0, ST_IDLE});
    check("step_count", {24'd0, instr_count}, {24'd0, m_count});

    run = 1'b1;
    wait_state(ST_FETCH, "rst_fetch");
    opcode = 3'b111; dest = 3'd5; src = 3'd1; zero_flag = 1'b1; pc = 4'd9;
    wait_state(ST_EXECUTE, "rst_execute");
    #2 reset = 1'b1;
    #1;
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("rst_count", {24'd0, instr_count}, 32'd0);
    check("rst_flag", {31'd0, flag_q}, 32'd0);
    @(negedge clk);
    check("rst_no_strobes", {28'd0, ir_load, rf_write_en, pc_inc, pc_load}, 32'd0);
    run   = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_idle", {29'd0, state}, {29'd0, ST_IDLE});
    check("rst_after_strobes", {29'd0, rf_write_en, pc_inc, pc_load}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
